// File: rtl/sort_pkg.sv
// Shared types and constants for the bubble-sort step sequencer.
package sort_pkg;

    localparam int BAR_IDX_W = 4;
    localparam int HEIGHT_MAX = 64;
    localparam int SHUF_BITS = $clog2(HEIGHT_MAX);

    // Fibonacci LFSR x^16+x^14+x^13+x^11 -> feedback from bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHUFFLE,
        ST_WAIT,
        ST_COMPARE,
        ST_SWAP,
        ST_NEXT,
        ST_DONE
    } sort_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sort_step_sequencer_if.sv
// Bar register file port: two combinational reads, one dual-element write.
interface sort_step_sequencer_if
    import sort_pkg::*;
#(
    parameter int HEIGHT_W = 7
);
    logic [BAR_IDX_W-1:0] rd_addr_a;
    logic [BAR_IDX_W-1:0] rd_addr_b;
    logic [HEIGHT_W-1:0]  rd_data_a;
    logic [HEIGHT_W-1:0]  rd_data_b;
    logic                 wr_en;
    logic [BAR_IDX_W-1:0] wr_addr;
    logic [HEIGHT_W-1:0]  wr_data_a;
    logic [HEIGHT_W-1:0]  wr_data_b;
    logic                 wr_pair;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data_a, wr_data_b, wr_pair,
        input  rd_data_a, rd_data_b
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data_a, wr_data_b, wr_pair,
        output rd_data_a, rd_data_b
    );
endinterface

// File: rtl/sort_pace_timer.sv
// Step pacing counter: counts while run, ticks on the last count and wraps.
module sort_pace_timer #(
    parameter int STEP_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(STEP_CYCLES);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == CW'(STEP_CYCLES - 1));

    // count while running, hold otherwise, clear on request or on tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/sort_step_sequencer.sv
// Paced in-place bubble sort controller over an external bar register file.
module sort_step_sequencer
    import sort_pkg::*;
#(
    parameter int          N_BARS      = 5,
    parameter int          HEIGHT_W    = 7,
    parameter int          STEP_CYCLES = 50000000,
    parameter int          CNT_W       = 8,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 step,
    input  logic                 shuffle,
    sort_step_sequencer_if.master rf,
    output logic                 busy,
    output logic                 done,
    output logic [BAR_IDX_W-1:0] active_j,
    output logic [BAR_IDX_W:0]   sorted_from,
    output logic [CNT_W-1:0]     cmp_cnt,
    output logic [CNT_W-1:0]     swap_cnt
);
    localparam logic [BAR_IDX_W-1:0] LAST_I = BAR_IDX_W'(N_BARS - 2);
    localparam logic [BAR_IDX_W-1:0] LAST_K = BAR_IDX_W'(N_BARS - 1);
    localparam logic [BAR_IDX_W:0]   NB     = (BAR_IDX_W+1)'(N_BARS);

    sort_state_t          state;
    logic [BAR_IDX_W-1:0] i, j, k;
    logic                 swapped;
    logic [15:0]          lfsr;
    logic                 wr_en_q, wr_pair_q;
    logic [BAR_IDX_W-1:0] wr_addr_q;
    logic [HEIGHT_W-1:0]  wr_a_q, wr_b_q;
    logic                 timer_run, timer_clear, timer_tick;

    function automatic logic [HEIGHT_W-1:0] bar_height(input logic [15:0] l);
        return HEIGHT_W'(l[SHUF_BITS-1:0]) + HEIGHT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    assign timer_run   = (state == ST_WAIT) && !pause;
    assign timer_clear = (state == ST_IDLE || state == ST_DONE) && start && !shuffle;

    sort_pace_timer #(.STEP_CYCLES(STEP_CYCLES)) u_pace (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (timer_run),
        .clear   (timer_clear),
        .tick    (timer_tick)
    );

    assign rf.rd_addr_a = j;
    assign rf.rd_addr_b = j + BAR_IDX_W'(1);
    assign rf.wr_en     = wr_en_q;
    assign rf.wr_pair   = wr_pair_q;
    assign rf.wr_addr   = wr_addr_q;
    assign rf.wr_data_a = wr_a_q;
    assign rf.wr_data_b = wr_b_q;

    assign busy        = !(state == ST_IDLE || state == ST_DONE);
    assign done        = (state == ST_DONE);
    assign active_j    = busy ? j : '0;
    assign sorted_from = (state == ST_DONE) ? '0 :
                         (state == ST_IDLE || state == ST_SHUFFLE) ? NB :
                         NB - {1'b0, i};

    // sort / shuffle sequencing; write strobe is registered so it coincides
    // with the SWAP and SHUFFLE states
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            swapped   <= 1'b0;
            lfsr      <= LFSR_SEED;
            cmp_cnt   <= '0;
            swap_cnt  <= '0;
            wr_en_q   <= 1'b0;
            wr_pair_q <= 1'b0;
            wr_addr_q <= '0;
            wr_a_q    <= '0;
            wr_b_q    <= '0;
        end else begin
            wr_en_q   <= 1'b0;
            wr_pair_q <= 1'b0;
            if (shuffle && (state inside {ST_IDLE, ST_DONE, ST_WAIT})) begin
                state     <= ST_SHUFFLE;
                k         <= '0;
                wr_en_q   <= 1'b1;
                wr_addr_q <= '0;
                wr_a_q    <= bar_height(lfsr);
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state    <= ST_WAIT;
                            i        <= '0;
                            j        <= '0;
                            swapped  <= 1'b0;
                            cmp_cnt  <= '0;
                            swap_cnt <= '0;
                        end
                    end
                    ST_SHUFFLE: begin
                        // write data is staged one cycle ahead from the advanced LFSR
                        lfsr <= lfsr_next(lfsr);
                        if (k == LAST_K) begin
                            state <= ST_IDLE;
                        end else begin
                            k         <= k + BAR_IDX_W'(1);
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= k + BAR_IDX_W'(1);
                            wr_a_q    <= bar_height(lfsr_next(lfsr));
                        end
                    end
                    ST_WAIT: begin
                        if ((!pause && timer_tick) || (pause && step))
                            state <= ST_COMPARE;
                    end
                    ST_COMPARE: begin
                        cmp_cnt <= sat_inc(cmp_cnt);
                        if (rf.rd_data_a > rf.rd_data_b) begin
                            state     <= ST_SWAP;
                            wr_en_q   <= 1'b1;
                            wr_pair_q <= 1'b1;
                            wr_addr_q <= j;
                            wr_a_q    <= rf.rd_data_b;
                            wr_b_q    <= rf.rd_data_a;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end
                    ST_SWAP: begin
                        swap_cnt <= sat_inc(swap_cnt);
                        swapped  <= 1'b1;
                        state    <= ST_NEXT;
                    end
                    ST_NEXT: begin
                        if (({1'b0, j} + {1'b0, i}) < (BAR_IDX_W+1)'(N_BARS - 2)) begin
                            j     <= j + BAR_IDX_W'(1);
                            state <= ST_WAIT;
                        end else if (!swapped || i == LAST_I) begin
                            state <= ST_DONE;
                        end else begin
                            i       <= i + BAR_IDX_W'(1);
                            j       <= '0;
                            swapped <= 1'b0;
                            state   <= ST_WAIT;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sort_step_sequencer.sv
// Self-checking bench for sort_step_sequencer with a behavioural bubble-sort model.
module tb_sort_step_sequencer;
    localparam int N  = 5;
    localparam int HW = 7;
    localparam int S  = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset_n, start, pause, step, shuffle;
    logic busy, done;
    logic [3:0] active_j;
    logic [4:0] sorted_from;
    logic [CW-1:0] cmp_cnt, swap_cnt;

    int errors = 0;
    int checks = 0;

    sort_step_sequencer_if #(.HEIGHT_W(HW)) rf();

    sort_step_sequencer #(
        .N_BARS(N), .HEIGHT_W(HW), .STEP_CYCLES(S), .CNT_W(CW), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .step(step),
        .shuffle(shuffle), .rf(rf), .busy(busy), .done(done), .active_j(active_j),
        .sorted_from(sorted_from), .cmp_cnt(cmp_cnt), .swap_cnt(swap_cnt)
    );

    always #5 clk = ~clk;

    // bar register file
    logic [HW-1:0] mem [N];
    logic [HW-1:0] load_val [N];
    logic load_req = 1'b0;

    always_comb begin
        rf.rd_data_a = '0;
        rf.rd_data_b = '0;
        if (int'(rf.rd_addr_a) < N) rf.rd_data_a = mem[int'(rf.rd_addr_a)];
        if (int'(rf.rd_addr_b) < N) rf.rd_data_b = mem[int'(rf.rd_addr_b)];
    end

    always @(posedge clk) begin
        if (load_req) begin
            for (int q = 0; q < N; q++) mem[q] <= load_val[q];
        end else if (rf.wr_en) begin
            if (int'(rf.wr_addr) < N) mem[int'(rf.wr_addr)] <= rf.wr_data_a;
            if (rf.wr_pair && int'(rf.wr_addr) + 1 < N) mem[int'(rf.wr_addr) + 1] <= rf.wr_data_b;
        end
    end

    // reference model state
    int m_in [N];
    int m_out [N];
    int m_cmp, m_swp, m_passes, m_cycles;
    logic [15:0] bl;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        bl = 16'hACE1;
    endtask

    task automatic load_array(input int a0, input int a1, input int a2, input int a3, input int a4);
        m_in[0] = a0; m_in[1] = a1; m_in[2] = a2; m_in[3] = a3; m_in[4] = a4;
        for (int q = 0; q < N; q++) load_val[q] = HW'(m_in[q]);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // plain early-exit bubble sort with pacing cost per compare
    task automatic model_sort();
        int a [N];
        int t;
        bit sw;
        for (int q = 0; q < N; q++) a[q] = m_in[q];
        m_cmp = 0; m_swp = 0; m_passes = 0; m_cycles = 0;
        for (int p = 0; p <= N - 2; p++) begin
            sw = 0;
            m_passes++;
            for (int x = 0; x <= N - 2 - p; x++) begin
                m_cmp++;
                if (a[x] > a[x+1]) begin
                    t = a[x]; a[x] = a[x+1]; a[x+1] = t;
                    m_swp++;
                    sw = 1;
                    m_cycles += S + 3;
                end else begin
                    m_cycles += S + 2;
                end
            end
            if (!sw) break;
        end
        for (int q = 0; q < N; q++) m_out[q] = a[q];
    endtask

    task automatic check_final(input string name);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done/busy: got %b/%b expected 1/0", name, done, busy);
        end
        checks++;
        if (cmp_cnt !== CW'(m_cmp)) begin
            errors++;
            $display("FAIL %s cmp_cnt: got %0d expected %0d", name, cmp_cnt, m_cmp);
        end
        checks++;
        if (swap_cnt !== CW'(m_swp)) begin
            errors++;
            $display("FAIL %s swap_cnt: got %0d expected %0d", name, swap_cnt, m_swp);
        end
        checks++;
        if (sorted_from !== 5'd0) begin
            errors++;
            $display("FAIL %s sorted_from: got %0d expected 0", name, sorted_from);
        end
        for (int q = 0; q < N; q++) begin
            checks++;
            if (mem[q] !== HW'(m_out[q])) begin
                errors++;
                $display("FAIL %s bar[%0d]: got %0d expected %0d", name, q, mem[q], m_out[q]);
            end
        end
    endtask

    // start a sort on the loaded file and check timing, pass boundary and result
    task automatic run_sort(input string name, input bit noisy);
        int cyc;
        int minsf;
        model_sort();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        minsf = N;
        while (!done && cyc < 1000) begin
            if (busy && int'(sorted_from) < minsf) minsf = int'(sorted_from);
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                step  = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        step  = 1'b0;
        checks++;
        if (cyc !== m_cycles) begin
            errors++;
            $display("FAIL %s cycles: got %0d expected %0d", name, cyc, m_cycles);
        end
        checks++;
        if (minsf !== N - (m_passes - 1)) begin
            errors++;
            $display("FAIL %s min sorted_from: got %0d expected %0d", name, minsf, N - (m_passes - 1));
        end
        check_final(name);
    endtask

    task automatic test_reset();
        start = 0; pause = 0; step = 0; shuffle = 0;
        do_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rf.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset flags: got busy=%b done=%b wr_en=%b expected 0/0/0", busy, done, rf.wr_en);
        end
        checks++;
        if (sorted_from !== 5'd5 || active_j !== 4'd0) begin
            errors++;
            $display("FAIL reset status: got sf=%0d aj=%0d expected 5/0", sorted_from, active_j);
        end
        checks++;
        if (cmp_cnt !== '0 || swap_cnt !== '0) begin
            errors++;
            $display("FAIL reset counters: got %0d/%0d expected 0/0", cmp_cnt, swap_cnt);
        end
        checks++;
        if (rf.rd_addr_a !== 4'd0 || rf.rd_addr_b !== 4'd1) begin
            errors++;
            $display("FAIL reset rd_addr: got %0d/%0d expected 0/1", rf.rd_addr_a, rf.rd_addr_b);
        end
    endtask

    task automatic test_directed();
        load_array(5, 4, 3, 2, 1);
        run_sort("reversed", 0);
        checks++;
        if (cmp_cnt !== 8'd10 || swap_cnt !== 8'd10) begin
            errors++;
            $display("FAIL reversed counts: got %0d/%0d expected 10/10", cmp_cnt, swap_cnt);
        end
        load_array(1, 2, 3, 4, 5);
        run_sort("sorted", 0);
        load_array(2, 2, 1, 3, 3);
        run_sort("equal", 0);
        checks++;
        if (swap_cnt !== 8'd2) begin
            errors++;
            $display("FAIL equal swap_cnt: got %0d expected 2", swap_cnt);
        end
    endtask

    task automatic test_random();
        int hi;
        for (int r = 0; r < 8; r++) begin
            hi = (r % 2 == 0) ? 64 : 4;
            load_array($urandom_range(1, hi), $urandom_range(1, hi), $urandom_range(1, hi),
                       $urandom_range(1, hi), $urandom_range(1, hi));
            run_sort("random", r >= 4);
        end
    endtask

    task automatic test_pause();
        int cyc;
        load_array(3, 1, 4, 1, 5);
        model_sort();
        pause = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        checks++;
        if (cmp_cnt !== '0 || active_j !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pause hold: got cmp=%0d aj=%0d busy=%b expected 0/0/1", cmp_cnt, active_j, busy);
        end
        repeat (3) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (4) tick();
        end
        checks++;
        if (active_j !== 4'd3 || cmp_cnt !== 8'd3) begin
            errors++;
            $display("FAIL pause steps: got aj=%0d cmp=%0d expected 3/3", active_j, cmp_cnt);
        end
        pause = 1'b0;
        cyc = 0;
        while (!done && cyc < 1000) begin
            tick();
            cyc++;
        end
        check_final("pause_resume");
    endtask

    task automatic shuffle_once(input string name, output int seq [N]);
        logic [15:0] l;
        l = bl;
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        for (int q = 0; q < N; q++) begin
            seq[q] = int'(l[5:0]) + 1;
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            checks++;
            if (rf.wr_en !== 1'b1 || rf.wr_pair !== 1'b0 || rf.wr_addr !== 4'(q) ||
                rf.wr_data_a !== HW'(seq[q]) || rf.wr_data_a < 1 || rf.wr_data_a > 64) begin
                errors++;
                $display("FAIL %s write %0d: got en=%b pair=%b addr=%0d data=%0d expected 1/0/%0d/%0d",
                         name, q, rf.wr_en, rf.wr_pair, rf.wr_addr, rf.wr_data_a, q, seq[q]);
            end
            tick();
        end
        bl = l;
        checks++;
        if (rf.wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sorted_from !== 5'd5) begin
            errors++;
            $display("FAIL %s end: got en=%b busy=%b done=%b sf=%0d expected idle", name, rf.wr_en, busy, done, sorted_from);
        end
        for (int q = 0; q < N; q++) m_in[q] = seq[q];
    endtask

    task automatic test_shuffle();
        int first [N];
        int again [N];
        do_reset();
        shuffle_once("shuffle1", first);
        shuffle_once("shuffle_cont", again);
        run_sort("shuffled_sort", 0);
        shuffle_once("shuffle_from_done", again);
        do_reset();
        shuffle_once("shuffle_reseed", again);
        for (int q = 0; q < N; q++) begin
            checks++;
            if (again[q] !== first[q]) begin
                errors++;
                $display("FAIL reseed seq[%0d]: got %0d expected %0d", q, again[q], first[q]);
            end
        end
    endtask

    task automatic test_reset_in_swap();
        int cyc;
        load_array(5, 4, 3, 2, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (rf.wr_en !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (rf.wr_en !== 1'b1) begin
            errors++;
            $display("FAIL swap_wait: got wr_en=%b expected 1 within 100 cycles", rf.wr_en);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (rf.wr_en !== 1'b0 || busy !== 1'b0 || cmp_cnt !== '0 || swap_cnt !== '0 || sorted_from !== 5'd5) begin
            errors++;
            $display("FAIL async_reset: got en=%b busy=%b cmp=%0d swp=%0d sf=%0d expected 0/0/0/0/5",
                     rf.wr_en, busy, cmp_cnt, swap_cnt, sorted_from);
        end
        tick();
        reset_n = 1'b1;
        bl = 16'hACE1;
    endtask

    task automatic test_start_while_busy();
        int cyc;
        load_array($urandom_range(1, 64), $urandom_range(1, 64), $urandom_range(1, 64),
                   $urandom_range(1, 64), $urandom_range(1, 64));
        model_sort();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (cmp_cnt !== 8'd2 && cyc < 200) begin
            tick();
            cyc++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (cmp_cnt !== 8'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: got cmp=%0d busy=%b expected 2/1", cmp_cnt, busy);
        end
        cyc = 0;
        while (!done && cyc < 1000) begin
            tick();
            cyc++;
        end
        check_final("start_busy_final");
    endtask

    initial begin
        bl = 16'hACE1;
        test_reset();
        test_directed();
        test_random();
        test_pause();
        test_shuffle();
        test_reset_in_swap();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sort_step_sequencer.md
Name: sort_step_sequencer

Overview:
- Paced controller that runs an in-place bubble sort over an external bar-height register file. The register file provides two combinational read ports and one dual-element write strobe.
- Issues one compare every STEP_CYCLES clocks, or one compare per step pulse while paused. Supports early exit when a pass makes no swap, and an LFSR shuffle of the array.
- Exports status that the OLED bar renderer uses for colouring: active pair, sorted boundary, busy/done.
- Sits between the switch/button debouncers and the bar register file + renderer.

Parameters:
N_BARS, 5, number of bars (2..16)
HEIGHT_W, 7, bits per bar height
STEP_CYCLES, 50000000, clocks between automatic compare steps (>=2)
CNT_W, 8, width of compare/swap statistic counters
LFSR_SEED, 16'hACE1, nonzero 16-bit shuffle seed

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin sort from IDLE or DONE
pause  in  1  level: freeze automatic pacing
step  in  1  single-cycle pulse: one compare while pause=1
shuffle  in  1  single-cycle pulse: load pseudo-random heights
rd_addr_a  out  4  index j to register file
rd_addr_b  out  4  index j+1
rd_data_a  in  HEIGHT_W  height[j] (combinational)
rd_data_b  in  HEIGHT_W  height[j+1]
wr_en  out  1  write strobe, one cycle
wr_addr  out  4  base index of write
wr_data_a  out  HEIGHT_W  value for height[wr_addr]
wr_data_b  out  HEIGHT_W  value for height[wr_addr+1] (ignored during shuffle)
wr_pair  out  1  1 = write both elements, 0 = write element a only
busy  out  1  state not IDLE/DONE
done  out  1  state DONE
active_j  out  4  left index of pair under compare
sorted_from  out  5  indices >= this are final (N_BARS when not sorting)
cmp_cnt  out  CNT_W  compares this sort, saturating
swap_cnt  out  CNT_W  swaps this sort, saturating

Behaviour:
- Reset (async, any state): state IDLE, i=j=0, pace counter 0, swapped flag 0, LFSR=LFSR_SEED, counters 0, wr_en=0, sorted_from=N_BARS, all other outputs 0.
- States: IDLE, SHUFFLE, WAIT, COMPARE, SWAP, NEXT, DONE.
- rd_addr_a=j and rd_addr_b=j+1 at all times.
- IDLE/DONE, start=1 -> WAIT. Clear i, j, pace counter, swapped flag and both counters.
- IDLE/DONE/WAIT, shuffle=1 -> SHUFFLE. Shuffle has priority over start in the same cycle. In SHUFFLE, for k=0..N_BARS-1, one write per cycle: wr_en=1, wr_pair=0, wr_addr=k, wr_data_a={0,lfsr[5:0]}+1 (range 1..64). LFSR is x^16+x^14+x^13+x^11 Fibonacci and advances every SHUFFLE cycle. After k=N_BARS-1 -> IDLE. Shuffle pulses in COMPARE/SWAP/NEXT are ignored.
- WAIT with pause=0: pace counter increments; on reaching STEP_CYCLES-1 it clears and the FSM goes to COMPARE.
- WAIT with pause=1: pace counter holds; step=1 -> COMPARE. Step is ignored when pause=0.
- COMPARE (1 cycle): cmp_cnt+1. If rd_data_a > rd_data_b (strict, unsigned) -> SWAP, else NEXT.
- SWAP (1 cycle): wr_en=1, wr_pair=1, wr_addr=j, wr_data_a=rd_data_b, wr_data_b=rd_data_a. swap_cnt+1, swapped=1 -> NEXT.
- NEXT: if j < N_BARS-2-i then j+1 -> WAIT.
- Pass end (otherwise): if swapped=0 or i==N_BARS-2 -> DONE. Else i+1, j=0, swapped=0 -> WAIT.
- Latency: exactly STEP_CYCLES+2 (no swap) or +3 (swap) clocks per pair when unpaused.
- sorted_from: N_BARS-i while busy; 0 in DONE; N_BARS in IDLE/SHUFFLE.
- active_j: equals j while busy.
- Counters saturate at all-ones.
- start while busy is ignored. pause has no effect outside WAIT.

Decomposition:
- Shared package sort_pkg: state enum, BAR_IDX_W=4, LFSR taps/seed, HEIGHT_MAX=64.
- Sub-module sort_pace_timer (STEP_CYCLES counter with hold/clear, tick output) is natural; the FSM instantiates it.

Test Plan:
- STEP_CYCLES=4, file [5,4,3,2,1], start -> DONE with file [1,2,3,4,5], cmp_cnt=10, swap_cnt=10, done=1, sorted_from=0.
- File [1,2,3,4,5], start -> DONE after first pass, cmp_cnt=4, swap_cnt=0, i stayed 0.
- File [2,2,1,3,3], start -> final [1,2,2,3,3]. No swap between equal elements; swap_cnt=2.
- pause=1 after start, wait 100 clocks -> no compare, active_j=0. Then 3 step pulses -> active_j=3, cmp_cnt=3.
- shuffle from IDLE -> five writes on consecutive cycles, wr_addr 0..4, each wr_data_a in 1..64, then IDLE. Same seed after reset gives an identical sequence.
- reset_n low during SWAP -> wr_en drops immediately (async), state IDLE, counters 0, sorted_from=5. Start pulse during busy -> no counter clear.
